// File: rtl/memory_multiport.sv
// rtl/memory_multiport.sv - multi-channel masked-write RAM with round-robin arbitration
module memory_multiport #(
    parameter int MEMORY_WIDTH  = 8,
    parameter int MEMORY_DEPTH  = 16,
    parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH),
    parameter int NUM_PORTS     = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_PORTS-1:0]              valid_i,
    input  logic [NUM_PORTS-1:0]              wr_rd_en_i,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS*MEMORY_WIDTH-1:0] wdata_i,
    input  logic [NUM_PORTS*MEMORY_WIDTH-1:0] wmask_i,
    output logic [NUM_PORTS-1:0]              ready_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [NUM_PORTS*MEMORY_WIDTH-1:0] rdata_o,
    output logic [NUM_PORTS-1:0]              err_o
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    logic [MEMORY_WIDTH-1:0]           mem [MEMORY_DEPTH];
    logic [PTR_W-1:0]                  rr_ptr;
    logic [PTR_W-1:0]                  grant_idx;
    logic [PTR_W:0]                    cand;
    logic [NUM_PORTS-1:0]              grant;
    logic                              accept;
    logic                              sel_wr;
    logic [ADDRESS_WIDTH-1:0]          sel_addr;
    logic [MEMORY_WIDTH-1:0]           sel_wdata;
    logic [MEMORY_WIDTH-1:0]           sel_wmask;
    logic                              in_range;
    logic [IDX_W-1:0]                  mem_idx;
    logic [NUM_PORTS-1:0]              rvalid_q;
    logic [NUM_PORTS-1:0]              err_q;
    logic [NUM_PORTS*MEMORY_WIDTH-1:0] rdata_q;

    // Cyclic search from rr_ptr for the first valid port; reset suppresses any grant.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
                cand = cand - (PTR_W+1)'(NUM_PORTS);
            end
            if (grant == '0 && valid_i[cand[PTR_W-1:0]] && !rst_i) begin
                grant[cand[PTR_W-1:0]] = 1'b1;
                grant_idx              = cand[PTR_W-1:0];
            end
        end
    end

    assign ready_o   = grant;
    assign accept    = |grant;
    assign sel_wr    = wr_rd_en_i[grant_idx];
    assign sel_addr  = addr_i[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign sel_wdata = wdata_i[int'(grant_idx)*MEMORY_WIDTH +: MEMORY_WIDTH];
    assign sel_wmask = wmask_i[int'(grant_idx)*MEMORY_WIDTH +: MEMORY_WIDTH];
    // Depth need not be a power of two, so range is checked explicitly instead of aliasing.
    assign in_range  = ({1'b0, sel_addr} < (ADDRESS_WIDTH+1)'(MEMORY_DEPTH));
    assign mem_idx   = sel_addr[IDX_W-1:0];

    // Storage: cleared on reset, bit-masked update for accepted in-range writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEMORY_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && sel_wr && in_range) begin
            mem[mem_idx] <= (mem[mem_idx] & ~sel_wmask) | (sel_wdata & sel_wmask);
        end
    end

    // Per-port read response and error pulses; rdata holds until the next read on that port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            err_q    <= '0;
            if (accept) begin
                err_q[grant_idx] <= !in_range;
                if (!sel_wr) begin
                    rvalid_q[grant_idx] <= 1'b1;
                    rdata_q[int'(grant_idx)*MEMORY_WIDTH +: MEMORY_WIDTH] <=
                        in_range ? mem[mem_idx] : '0;
                end
            end
        end
    end

    // Round-robin pointer moves past the granted port; holds when nothing is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_PORTS-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_memory_multiport.sv
// tb/tb_memory_multiport.sv - table-driven scoreboard bench for memory_multiport
module tb_memory_multiport;

    localparam int W  = 8;
    localparam int D  = 12;
    localparam int AW = 4;
    localparam int NP = 2;

    logic           clk;
    logic           rst;
    logic [NP-1:0]  valid;
    logic [NP-1:0]  wr;
    logic [NP*AW-1:0] addr;
    logic [NP*W-1:0]  wdata;
    logic [NP*W-1:0]  wmask;
    logic [NP-1:0]  ready;
    logic [NP-1:0]  rvalid;
    logic [NP*W-1:0]  rdata;
    logic [NP-1:0]  err;

    typedef struct {
        logic       r;
        logic [1:0] v;
        logic [1:0] wr;
        logic [3:0] a0;
        logic [7:0] d0;
        logic [7:0] m0;
        logic [3:0] a1;
        logic [7:0] d1;
        logic [7:0] m1;
        logic [1:0] er;
    } vec_t;

    typedef struct {
        int         port;
        logic       is_read;
        logic       err;
        logic [7:0] data;
    } exp_t;

    vec_t       tbl[$];
    exp_t       exp_q[$];
    logic [7:0] mm [D];
    logic [7:0] hold [NP];
    int         pass_cnt;
    int         total_cnt;

    memory_multiport #(
        .MEMORY_WIDTH (W),
        .MEMORY_DEPTH (D),
        .ADDRESS_WIDTH(AW),
        .NUM_PORTS    (NP)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .wr_rd_en_i(wr),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .wmask_i   (wmask),
        .ready_o   (ready),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] w,
                                input logic [3:0] a0, input logic [7:0] d0, input logic [7:0] m0,
                                input logic [3:0] a1, input logic [7:0] d1, input logic [7:0] m1,
                                input logic [1:0] er);
        vec_t t;
        t.r = r; t.v = v; t.wr = w;
        t.a0 = a0; t.d0 = d0; t.m0 = m0;
        t.a1 = a1; t.d1 = d1; t.m1 = m1;
        t.er = er;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // One cycle: drive, check grant mid-cycle, push expectations, clock, score outputs.
    task automatic run_vec(input vec_t t, input string tag);
        logic [3:0] pa;
        logic [7:0] pd;
        logic [7:0] pm;
        logic       pwr;
        exp_t       e;
        logic [1:0] ev;
        logic [1:0] ee;
        rst   = t.r;
        valid = t.v;
        wr    = t.wr;
        addr  = {t.a1, t.a0};
        wdata = {t.d1, t.d0};
        wmask = {t.m1, t.m0};
        #4;
        check({tag, "/ready"}, 32'(ready), 32'(t.er));
        for (int p = 0; p < NP; p++) begin
            if (t.er[p]) begin
                pa  = (p == 1) ? t.a1 : t.a0;
                pwr = t.wr[p];
                if (!pwr || pa >= 4'(D)) begin
                    e.port    = p;
                    e.is_read = !pwr;
                    e.err     = (pa >= 4'(D));
                    e.data    = (!pwr && pa < 4'(D)) ? mm[pa] : 8'h00;
                    exp_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        if (t.r) begin
            for (int i = 0; i < D; i++) mm[i] = 8'h00;
            for (int p = 0; p < NP; p++) hold[p] = 8'h00;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (t.er[p]) begin
                    pa  = (p == 1) ? t.a1 : t.a0;
                    pd  = (p == 1) ? t.d1 : t.d0;
                    pm  = (p == 1) ? t.m1 : t.m0;
                    pwr = t.wr[p];
                    if (pwr && pa < 4'(D)) mm[pa] = (mm[pa] & ~pm) | (pd & pm);
                    if (!pwr) hold[p] = (pa < 4'(D)) ? mm[pa] : 8'h00;
                end
            end
        end
        if (rvalid != 2'b00 || err != 2'b00) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL %s/unexpected: rvalid=%b err=%b required none", tag, rvalid, err);
            end else begin
                e  = exp_q.pop_front();
                ev = 2'(e.is_read) << e.port;
                ee = 2'(e.err) << e.port;
                check({tag, "/rvalid"}, 32'(rvalid), 32'(ev));
                check({tag, "/err"}, 32'(err), 32'(ee));
                if (e.is_read) check({tag, "/rdata_sb"}, 32'(8'(rdata >> (8*e.port))), 32'(e.data));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            $display("FAIL %s/missing: no response, required port %0d data %0h err %0b",
                     tag, e.port, e.data, e.err);
        end
        check({tag, "/rdata_hold"}, 32'(rdata), 32'({hold[1], hold[0]}));
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1; valid = '0; wr = '0; addr = '0; wdata = '0; wmask = '0;
        for (int i = 0; i < D; i++) mm[i] = 8'h00;
        for (int p = 0; p < NP; p++) hold[p] = 8'h00;

        // reset, then first read
        tbl.push_back(mk(1, 2'b00, 2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(1, 2'b11, 2'b00, 4'd5, 8'h00, 8'h00, 4'd5, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 2'b01, 2'b00, 4'd5, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b01));
        // masked write then readback (0xAC)
        tbl.push_back(mk(0, 2'b01, 2'b01, 4'd3, 8'hA5, 8'hFF, 4'd0, 8'h00, 8'h00, 2'b01));
        tbl.push_back(mk(0, 2'b01, 2'b01, 4'd3, 8'h3C, 8'h0F, 4'd0, 8'h00, 8'h00, 2'b01));
        tbl.push_back(mk(0, 2'b01, 2'b00, 4'd3, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b01));
        tbl.push_back(mk(0, 2'b00, 2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b00));
        // contention after reset: p0, p1, p0, p1
        tbl.push_back(mk(1, 2'b00, 2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b11, 4'd1, 8'h11, 8'hFF, 4'd2, 8'h22, 8'hFF, 2'b01));
        tbl.push_back(mk(0, 2'b11, 2'b11, 4'd1, 8'h33, 8'hFF, 4'd2, 8'h22, 8'hFF, 2'b10));
        tbl.push_back(mk(0, 2'b11, 2'b11, 4'd1, 8'h33, 8'hFF, 4'd2, 8'h44, 8'hFF, 2'b01));
        tbl.push_back(mk(0, 2'b11, 2'b11, 4'd1, 8'h55, 8'hFF, 4'd2, 8'h44, 8'hFF, 2'b10));
        tbl.push_back(mk(0, 2'b11, 2'b01, 4'd1, 8'h55, 8'hFF, 4'd2, 8'h00, 8'h00, 2'b01));
        tbl.push_back(mk(0, 2'b11, 2'b00, 4'd1, 8'h00, 8'h00, 4'd2, 8'h00, 8'h00, 2'b10));
        tbl.push_back(mk(0, 2'b01, 2'b00, 4'd1, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b01));
        // out of range read/write, then last in-range word with a partial mask
        tbl.push_back(mk(0, 2'b10, 2'b00, 4'd0, 8'h00, 8'h00, 4'd12, 8'h00, 8'h00, 2'b10));
        tbl.push_back(mk(0, 2'b10, 2'b10, 4'd0, 8'h00, 8'h00, 4'd15, 8'hFF, 8'hFF, 2'b10));
        tbl.push_back(mk(0, 2'b10, 2'b10, 4'd0, 8'h00, 8'h00, 4'd11, 8'h5A, 8'hF0, 2'b10));
        // lone requester: back-to-back reads of every word
        for (int k = 0; k < D; k++)
            tbl.push_back(mk(0, 2'b01, 2'b00, 4'(k), 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b01));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of streaming traffic; read accepted just before reset loses nothing observable afterward
        run_vec(mk(0, 2'b11, 2'b10, 4'd2, 8'h00, 8'h00, 4'd6, 8'hB2, 8'hFF, 2'b10), "rst_mid0");
        run_vec(mk(0, 2'b11, 2'b10, 4'd2, 8'h00, 8'h00, 4'd7, 8'hB3, 8'hFF, 2'b01), "rst_mid1");
        run_vec(mk(1, 2'b11, 2'b11, 4'd5, 8'hC4, 8'hFF, 4'd7, 8'hB3, 8'hFF, 2'b00), "rst_mid2");
        run_vec(mk(1, 2'b11, 2'b11, 4'd5, 8'hC4, 8'hFF, 4'd7, 8'hB3, 8'hFF, 2'b00), "rst_mid3");
        run_vec(mk(0, 2'b11, 2'b00, 4'd4, 8'h00, 8'h00, 4'd6, 8'h00, 8'h00, 2'b01), "rst_post0");
        run_vec(mk(0, 2'b11, 2'b00, 4'd5, 8'h00, 8'h00, 4'd6, 8'h00, 8'h00, 2'b10), "rst_post1");
        for (int k = 0; k < D; k++)
            run_vec(mk(0, 2'b01, 2'b00, 4'(k), 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b01),
                    $sformatf("rst_rb%0d", k));
        run_vec(mk(0, 2'b00, 2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b00), "drain");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
